// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite master transaction controller
// among NREQ requesters, launching each latched command and returning its result.
module axil_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     m_start,
  output logic                     m_r_w,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  output logic                     m_abort,
  input  logic                     m_idle,
  input  logic                     m_tr_complete,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic                     m_resp_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TIMEOUT > 65535) ? $clog2(TIMEOUT + 1) : 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [CNT_W-1:0]   cnt;
  logic               timeout_hit;

  // Scan downward so the last match is the first set bit after 'last'.
  always_comb begin
    win_idx = last;
    win_vld = |req;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ])
        win_idx = IDX_W'((int'(last) + k) % NREQ);
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ISSUE;
      ISSUE:   if (m_idle) state_nxt = WAIT;
      WAIT:    if (m_tr_complete || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign m_start = (state == ISSUE);
  assign done    = (state == DONE) ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= IDX_W'(NREQ - 1);
      idx     <= '0;
      grant   <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      m_r_w   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_abort <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      m_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            idx     <= win_idx;
            grant   <= NREQ'(1) << win_idx;
            m_r_w   <= req_rw[win_idx];
            m_addr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            m_wdata <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // Completion takes precedence over a timeout in the same cycle.
          if (m_tr_complete) begin
            rdata <= m_r_w ? '0 : m_rdata;
            err   <= m_resp_err;
          end else if (timeout_hit) begin
            m_abort <= 1'b1;
            err     <= 1'b1;
            rdata   <= '0;
          end
        end
        DONE: begin
          last  <= idx;
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter: table of complete transactions plus
// hand sequences for timeout, completion/timeout tie and reset during WAIT.
module tb_axil_req_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, req_rw;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   grant, done;
  logic [DW-1:0]     rdata;
  logic              err, m_start, m_r_w, m_abort;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic              m_idle, m_tr_complete, m_resp_err;
  logic [DW-1:0]     m_rdata;

  int n_total = 0;
  int n_pass  = 0;

  axil_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .done(done), .rdata(rdata), .err(err),
    .m_start(m_start), .m_r_w(m_r_w), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_abort(m_abort), .m_idle(m_idle), .m_tr_complete(m_tr_complete),
    .m_rdata(m_rdata), .m_resp_err(m_resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        resp;
    int          idle_dly;
    int          comp_dly;
    logic [3:0]  exp_grant;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_nstart;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int n, input vec_t t);
    int  w;
    int  ns;
    bit  go;
    string tag;
    tag = $sformatf("v%0d", n);
    w = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (t.exp_grant[i]) w = i;
      req_addr[i*AW +: AW]  = 32'hBAD0_0000 | 32'(i);
      req_wdata[i*DW +: DW] = 32'h5A5A_0000 | 32'(i);
    end
    req_addr[w*AW +: AW]  = t.addr;
    req_wdata[w*DW +: DW] = t.wdata;
    req_rw     = t.rw;
    req        = t.req;
    m_rdata    = t.mrdata;
    m_resp_err = t.resp;
    tick();
    chk({tag, " grant"},   grant,   t.exp_grant);
    chk({tag, " m_addr"},  m_addr,  t.addr);
    chk({tag, " m_wdata"}, m_wdata, t.wdata);
    chk({tag, " m_r_w"},   m_r_w,   t.rw[w]);
    ns = 0;
    go = 0;
    for (int c = 0; c < 40 && !go; c++) begin
      m_idle = (c >= t.idle_dly);
      if (m_start) ns++;
      go = m_start && m_idle;
      tick();
    end
    m_idle = 1'b0;
    chk({tag, " start_cycles"}, ns, t.exp_nstart);
    chk({tag, " start_low_wait"}, m_start, 1'b0);
    repeat (t.comp_dly - 1) tick();
    m_tr_complete = 1'b1;
    tick();
    m_tr_complete = 1'b0;
    m_rdata = 32'hFFFF_FFFF;
    chk({tag, " done"},    done,    t.exp_grant);
    chk({tag, " rdata"},   rdata,   t.exp_rdata);
    chk({tag, " err"},     err,     t.exp_err);
    chk({tag, " abort"},   m_abort, 1'b0);
    chk({tag, " rw_hold"}, m_r_w,   t.rw[w]);
    m_idle = 1'b1;
    tick();
    chk({tag, " done_1cyc"},  done,  4'b0000);
    chk({tag, " grant_clr"},  grant, 4'b0000);
    chk({tag, " rdata_hold"}, rdata, t.exp_rdata);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{4'b0001, 4'b0001, 32'h10,  32'hDEADBEEF, 32'hAAAA5555, 1'b0, 0, 5, 4'b0001, 32'h0,        1'b0, 1};
    vecs[1] = '{4'b0100, 4'b0000, 32'h24,  32'h0,        32'h12345678, 1'b0, 0, 3, 4'b0100, 32'h12345678, 1'b0, 1};
    vecs[2] = '{4'b1010, 4'b0000, 32'h30,  32'h0,        32'hCAFEF00D, 1'b1, 3, 2, 4'b1000, 32'hCAFEF00D, 1'b1, 4};
    vecs[3] = '{4'b1111, 4'b0101, 32'h100, 32'h11111111, 32'h99999999, 1'b0, 0, 1, 4'b0001, 32'h0,        1'b0, 1};
    vecs[4] = '{4'b1111, 4'b0101, 32'h104, 32'h0,        32'hA1A1A1A1, 1'b0, 0, 2, 4'b0010, 32'hA1A1A1A1, 1'b0, 1};
    vecs[5] = '{4'b1111, 4'b0101, 32'h108, 32'h22222222, 32'h0,        1'b1, 0, 1, 4'b0100, 32'h0,        1'b1, 1};
    vecs[6] = '{4'b1111, 4'b0101, 32'h10C, 32'h0,        32'hB2B2B2B2, 1'b0, 1, 4, 4'b1000, 32'hB2B2B2B2, 1'b0, 2};
    vecs[7] = '{4'b1111, 4'b0101, 32'h110, 32'h33333333, 32'h0,        1'b0, 0, 1, 4'b0001, 32'h0,        1'b0, 1};
    vecs[8] = '{4'b0011, 4'b0000, 32'h200, 32'h0,        32'h0000FFFF, 1'b0, 0, 2, 4'b0010, 32'h0000FFFF, 1'b0, 1};
    vecs[9] = '{4'b0011, 4'b0000, 32'h204, 32'h0,        32'h0F0F0F0F, 1'b0, 0, 1, 4'b0001, 32'h0F0F0F0F, 1'b0, 1};

    reset = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    m_idle = 1'b1; m_tr_complete = 1'b0; m_rdata = '0; m_resp_err = 1'b0;
    repeat (3) tick();
    chk("rst grant", grant, 4'b0);
    chk("rst done", done, 4'b0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst err", err, 1'b0);
    chk("rst m_start", m_start, 1'b0);
    chk("rst m_addr", m_addr, 32'h0);
    chk("rst m_wdata", m_wdata, 32'h0);
    chk("rst m_abort", m_abort, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
    req = '0;

    // Timeout on a read: abort 8 cycles after WAIT entry, rdata forced to 0.
    req_rw = 4'b0000; req_addr[0 +: AW] = 32'h300; m_rdata = 32'h77777777;
    req = 4'b0001;
    tick();
    chk("to grant", grant, 4'b0001);
    tick();
    req = '0; m_idle = 1'b0;
    cyc = 0;
    while (!m_abort && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("to abort_delay", cyc, 8);
    chk("to done", done, 4'b0001);
    chk("to err", err, 1'b1);
    chk("to rdata", rdata, 32'h0);
    m_idle = 1'b1;
    tick();
    chk("to abort_1cyc", m_abort, 1'b0);
    chk("to done_1cyc", done, 4'b0000);

    // Completion on the final allowed WAIT cycle wins over the timeout.
    req_addr[1*AW +: AW] = 32'h304; m_rdata = 32'h6789ABCD; m_resp_err = 1'b0;
    req = 4'b0010;
    tick();
    chk("tie grant", grant, 4'b0010);
    tick();
    req = '0; m_idle = 1'b0;
    repeat (7) tick();
    m_tr_complete = 1'b1;
    tick();
    m_tr_complete = 1'b0;
    chk("tie abort", m_abort, 1'b0);
    chk("tie done", done, 4'b0010);
    chk("tie err", err, 1'b0);
    chk("tie rdata", rdata, 32'h6789ABCD);
    m_idle = 1'b1;
    tick();
    chk("tie abort_late", m_abort, 1'b0);

    // Reset while WAITing discards the command and restores priority to 0.
    req_addr[2*AW +: AW] = 32'h308; req_wdata[2*DW +: DW] = 32'h13579BDF;
    req_rw = 4'b0100;
    req = 4'b0100;
    tick();
    tick();
    req = '0; m_idle = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr grant", grant, 4'b0);
    chk("mr done", done, 4'b0);
    chk("mr m_start", m_start, 1'b0);
    chk("mr m_r_w", m_r_w, 1'b0);
    chk("mr m_addr", m_addr, 32'h0);
    chk("mr m_wdata", m_wdata, 32'h0);
    chk("mr rdata", rdata, 32'h0);
    chk("mr err", err, 1'b0);
    m_idle = 1'b1;
    m_tr_complete = 1'b1;
    tick();
    m_tr_complete = 1'b0;
    chk("mr no_done", done, 4'b0);
    chk("mr idle_start", m_start, 1'b0);
    req = 4'b1111;
    tick();
    chk("mr first_grant", grant, 4'b0001);
    chk("mr issue_start", m_start, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
